// File: rtl/slot_counter_bank.sv
// rtl/slot_counter_bank.sv - multi-channel counter bank with snapshot handshake onto HEDIOS slots
//
// Purpose: CHANNELS independent WIDTH-bit counters clocked on slower_clock, each
// with its own mode/enable/clear, sharing one prescaler tick. A req/ack
// handshake freezes a coherent copy of all counters into the slot bus.
// Optional build macro: COUNTER_BANK_OVF_EN adds a sticky per-channel overflow
// flag that is reported in slot bit SLOT_WIDTH-1.
//
// Ports:
//   slower_clock  in   counter clock
//   rst           in   asynchronous active-high reset
//   en            in   [CHANNELS]            per-channel count enable
//   clr           in   [CHANNELS]            per-channel synchronous clear
//   mode          in   [2*CHANNELS]          ch i = mode[2i+1:2i]
//                                            00 up-wrap, 01 down-wrap, 10 up-sat, 11 hold
//   snap_req      in   snapshot request (level)
//   snap_ack      in   consumer has read the snapshot
//   snap_valid    out  slots hold a frozen snapshot
//   count         out  [CHANNELS*WIDTH]      live counters, ch0 in LSBs
//   slots         out  [CHANNELS*SLOT_WIDTH] snapshot, ch i in slot i bits [WIDTH-1:0]
module slot_counter_bank #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int SLOT_WIDTH = 32,
  parameter int PRESCALE   = 1
) (
  input  logic                           slower_clock,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            en,
  input  logic [CHANNELS-1:0]            clr,
  input  logic [2*CHANNELS-1:0]          mode,
  input  logic                           snap_req,
  input  logic                           snap_ack,
  output logic                           snap_valid,
  output logic [CHANNELS*WIDTH-1:0]      count,
  output logic [CHANNELS*SLOT_WIDTH-1:0] slots
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  logic [PW-1:0]                          presc_q, presc_d;
  logic                                   tick;
  logic [CHANNELS-1:0][WIDTH-1:0]         cnt_q, cnt_d;
  logic [CHANNELS-1:0]                    wrap;
  logic [CHANNELS-1:0][SLOT_WIDTH-1:0]    slots_q, slots_d;
  logic                                   valid_q, valid_d;
  state_t                                 state_q, state_d;

  // Free-running prescaler; tick fires on the zero phase so the first cycle
  // after reset already counts.
  assign tick    = (presc_q == '0);
  assign presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);

  // Counter next state. wrap marks a step taken across (or against, for the
  // saturating mode) the range boundary; it feeds the optional overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (en[i] && tick) begin
        case (mode[2*i +: 2])
          2'b00: begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
            wrap[i]  = (cnt_q[i] == '1);
          end
          2'b01: begin
            cnt_d[i] = cnt_q[i] - WIDTH'(1);
            wrap[i]  = (cnt_q[i] == '0);
          end
          2'b10: begin
            if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + WIDTH'(1);
            wrap[i] = (cnt_q[i] == '1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef COUNTER_BANK_OVF_EN
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic                capture;

  assign capture = (state_q == S_CAPTURE);
  // The capture cycle hands the flag over to the slot and restarts it, but a
  // wrap in that very cycle must not be lost.
  assign ovf_d   = ((capture ? '0 : ovf_q) | wrap) & ~clr;

  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end
`endif

  // Snapshot FSM. Capture uses cnt_q, i.e. values before this cycle's update,
  // so a clear on the capture cycle still reports the pre-clear value.
  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (snap_req) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        for (int i = 0; i < CHANNELS; i++) begin
          slots_d[i] = SLOT_WIDTH'(cnt_q[i]);
`ifdef COUNTER_BANK_OVF_EN
          slots_d[i][SLOT_WIDTH-1] = ovf_q[i];
`endif
        end
        valid_d = 1'b1;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (snap_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      slots_q <= '0;
      valid_q <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign count      = cnt_q;
  assign slots      = slots_q;
  assign snap_valid = valid_q;

endmodule

// File: tb/tb_slot_counter_bank.sv
// tb/tb_slot_counter_bank.sv - self-checking bench for slot_counter_bank
module tb_slot_counter_bank;

`ifdef COUNTER_BANK_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en = '0, clr = '0;
  logic [3:0]  mode = '0;
  logic        req = 1'b0, ack = 1'b0;
  logic        valid;
  logic [15:0] count;
  logic [63:0] slots;

  logic [1:0]  en4 = '0, clr4 = '0;
  logic [3:0]  mode4 = '0;
  logic        req4 = 1'b0, ack4 = 1'b0;
  logic        valid4;
  logic [15:0] count4;
  logic [63:0] slots4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slot_counter_bank #(.CHANNELS(2), .WIDTH(8), .SLOT_WIDTH(32), .PRESCALE(1)) dut (
    .slower_clock(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .snap_req(req), .snap_ack(ack), .snap_valid(valid), .count(count), .slots(slots)
  );

  slot_counter_bank #(.CHANNELS(2), .WIDTH(8), .SLOT_WIDTH(32), .PRESCALE(4)) dut4 (
    .slower_clock(clk), .rst(rst), .en(en4), .clr(clr4), .mode(mode4),
    .snap_req(req4), .snap_ack(ack4), .snap_valid(valid4), .count(count4), .slots(slots4)
  );

  // Reference model: plain integer arithmetic on counter values plus a small
  // description of the handshake (a capture is pending / a snapshot is held).
  int m_cnt[2];
  int m_slot[2];
  bit m_slot_ovf[2];
  bit m_ovf[2];
  bit m_valid, m_cap;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_slot[i] = 0; m_slot_ovf[i] = 0; m_ovf[i] = 0;
    end
    m_valid = 0; m_cap = 0;
  endtask

  task automatic model_step();
    int pre[2];
    bit wr[2];
    bit was_cap;
    for (int i = 0; i < 2; i++) begin
      int md;
      pre[i] = m_cnt[i];
      wr[i]  = 0;
      md     = int'(mode[2*i +: 2]);
      if (clr[i]) m_cnt[i] = 0;
      else if (en[i]) begin
        if (md == 0) begin wr[i] = (pre[i] == 255); m_cnt[i] = (pre[i] + 1) % 256; end
        else if (md == 1) begin wr[i] = (pre[i] == 0); m_cnt[i] = (pre[i] + 255) % 256; end
        else if (md == 2) begin wr[i] = (pre[i] == 255); m_cnt[i] = (pre[i] < 255) ? pre[i] + 1 : 255; end
      end
    end
    was_cap = m_cap;
    if (m_cap) begin
      for (int i = 0; i < 2; i++) begin
        m_slot[i] = pre[i]; m_slot_ovf[i] = m_ovf[i];
      end
      m_valid = 1; m_cap = 0;
    end else if (m_valid) begin
      if (ack) m_valid = 0;
    end else if (req) begin
      m_cap = 1;
    end
    for (int i = 0; i < 2; i++) begin
      m_ovf[i] = ((was_cap ? 1'b0 : m_ovf[i]) | wr[i]) & ~clr[i];
    end
  endtask

  function automatic logic [63:0] exp_slots();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      r[32*i +: 8]  = 8'(m_slot[i]);
      r[32*i + 31]  = OVF & m_slot_ovf[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0; clr = '0; mode = '0; req = 1'b0; ack = 1'b0;
    en4 = '0; clr4 = '0; mode4 = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] en, clr;
    logic [3:0] mode;
    logic       req, ack;
    logic [7:0] c0, c1;
    logic       v;
    logic [7:0] s0, s1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    logic [63:0] mask;
    logic [7:0]  s_hold;

    //            en     clr    mode     req  ack   c0     c1     v     s0     s1
    vecs[0] = '{2'b11, 2'b00, 4'b0100, 1'b0, 1'b0, 8'd1, 8'd255, 1'b0, 8'd0, 8'd0};
    vecs[1] = '{2'b11, 2'b00, 4'b0100, 1'b1, 1'b0, 8'd2, 8'd254, 1'b0, 8'd0, 8'd0};
    vecs[2] = '{2'b11, 2'b00, 4'b0100, 1'b0, 1'b0, 8'd3, 8'd253, 1'b1, 8'd2, 8'd254};
    vecs[3] = '{2'b01, 2'b00, 4'b0100, 1'b0, 1'b0, 8'd4, 8'd253, 1'b1, 8'd2, 8'd254};
    vecs[4] = '{2'b01, 2'b10, 4'b0100, 1'b0, 1'b1, 8'd5, 8'd0,   1'b0, 8'd2, 8'd254};
    vecs[5] = '{2'b11, 2'b11, 4'b0100, 1'b0, 1'b0, 8'd0, 8'd0,   1'b0, 8'd2, 8'd254};
    vecs[6] = '{2'b11, 2'b00, 4'b1110, 1'b0, 1'b0, 8'd1, 8'd0,   1'b0, 8'd2, 8'd254};
    vecs[7] = '{2'b11, 2'b00, 4'b1011, 1'b1, 1'b1, 8'd1, 8'd1,   1'b0, 8'd2, 8'd254};
    vecs[8] = '{2'b00, 2'b01, 4'b1011, 1'b0, 1'b0, 8'd0, 8'd1,   1'b1, 8'd1, 8'd1};
    mask = 64'h7FFF_FFFF_7FFF_FFFF;

    do_reset();
    chk("reset_count", 64'(count), 64'h0);
    chk("reset_valid", 64'(valid), 64'h0);
    chk("reset_slots", slots, 64'h0);

    // Table vectors
    for (int k = 0; k < 9; k++) begin
      en = vecs[k].en; clr = vecs[k].clr; mode = vecs[k].mode;
      req = vecs[k].req; ack = vecs[k].ack;
      tick();
      chk($sformatf("vec%0d_count", k), 64'(count), 64'({vecs[k].c1, vecs[k].c0}));
      chk($sformatf("vec%0d_valid", k), 64'(valid), 64'(vecs[k].v));
      chk($sformatf("vec%0d_slots", k), slots & mask,
          {24'h0, vecs[k].s1, 24'h0, vecs[k].s0});
    end

    // Up-wrap over 260 cycles, down-wrap over 3 cycles
    do_reset();
    mode = 4'b0100; en = 2'b11;
    for (int k = 0; k < 3; k++) tick();
    en = 2'b01;
    for (int k = 0; k < 257; k++) tick();
    chk("wrap_up_260", 64'(count[7:0]), 64'd4);
    chk("wrap_down_3", 64'(count[15:8]), 64'd253);

    // Saturation and overflow flag capture/restart
    do_reset();
    mode = 4'b0010; en = 2'b01;
    for (int k = 0; k < 300; k++) tick();
    chk("sat_300", 64'(count[7:0]), 64'd255);
    en = 2'b00; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("sat_snap1_valid", 64'(valid), 64'd1);
    chk("sat_snap1_val", 64'(slots[7:0]), 64'd255);
    chk("sat_snap1_ovf", 64'(slots[31]), 64'(OVF));
    ack = 1'b1; tick(); ack = 1'b0;
    req = 1'b1; tick(); req = 1'b0; tick();
    chk("sat_snap2_ovf", 64'(slots[31]), 64'd0);
    ack = 1'b1; tick(); ack = 1'b0;

    // Snapshot latency, frozen slots while counting runs, ack release
    do_reset();
    mode = 4'b0000; en = 2'b01;
    for (int k = 0; k < 16; k++) tick();
    en = 2'b00; req = 1'b1;
    tick();
    req = 1'b0;
    chk("lat_valid_1cyc", 64'(valid), 64'd0);
    tick();
    chk("lat_valid_2cyc", 64'(valid), 64'd1);
    chk("snap_0x10", 64'(slots[7:0]), 64'h10);
    en = 2'b01;
    tick(); tick();
    chk("run_during_valid", 64'(count[7:0]), 64'h12);
    chk("slots_frozen", 64'(slots[7:0]), 64'h10);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_drops_valid", 64'(valid), 64'd0);

    // Prescaler 4 and clear-over-enable priority
    do_reset();
    en4 = 2'b01;
    for (int k = 0; k < 16; k++) tick();
    chk("presc4_16", 64'(count4), 64'd4);
    clr4 = 2'b01;
    tick();
    chk("presc4_clr_en", 64'(count4), 64'd0);
    clr4 = 2'b00; en4 = 2'b00;

    // ack while idle ignored; held request re-arms 3 cycles after each ack
    do_reset();
    ack = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("idle_ack_ignored", 64'(valid), 64'd0);
    ack = 1'b0; req = 1'b1;
    n = 0;
    while (!valid && n < 10) begin tick(); n++; end
    chk("first_req_latency", 64'(n), 64'd2);
    for (int r = 0; r < 2; r++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk($sformatf("rearm%0d_drop", r), 64'(valid), 64'd0);
      n = 1;
      while (!valid && n < 10) begin tick(); n++; end
      chk($sformatf("rearm%0d_latency", r), 64'(n), 64'd3);
    end
    req = 1'b0;

    // Randomized run against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en   = 2'($urandom);
      clr  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      mode = 4'($urandom);
      req  = ($urandom_range(0, 3) == 0);
      ack  = 1'($urandom);
      tick();
      chk("rand_count", 64'(count), 64'({8'(m_cnt[1]), 8'(m_cnt[0])}));
      chk("rand_valid", 64'(valid), 64'(m_valid));
      chk("rand_slots", slots, exp_slots());
    end

    // Asynchronous reset in the middle of a held snapshot
    do_reset();
    mode = 4'b0000; en = 2'b11; req = 1'b1;
    tick(); req = 1'b0; tick(); tick();
    s_hold = slots[7:0];
    chk("pre_rst_valid", 64'(valid), 64'd1);
    chk("pre_rst_slot", 64'(s_hold), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'h0);
    chk("async_rst_valid", 64'(valid), 64'h0);
    chk("async_rst_slots", slots, 64'h0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
